// File: rtl/mem_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module      : mem_arbiter_if
// Description : Requester-side and memory-side signals of mem_arbiter.
// Revision    : 1.0 - initial release
// =====================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              p0_valid;
  logic              p0_rw;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ready;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_valid;
  logic              p1_rw;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ready;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_valid, p0_rw, p0_addr, p0_wdata,
    output p0_ready, p0_rdata, p0_err,
    input  p1_valid, p1_rw, p1_addr, p1_wdata,
    output p1_ready, p1_rdata, p1_err,
    output mem_valid, mem_rw, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  // Requesters plus memory
  modport master (
    output p0_valid, p0_rw, p0_addr, p0_wdata,
    input  p0_ready, p0_rdata, p0_err,
    output p1_valid, p1_rw, p1_addr, p1_wdata,
    input  p1_ready, p1_rdata, p1_err,
    input  mem_valid, mem_rw, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =====================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of one memory
//               port, with a per-grant response timeout.
// Revision    : 1.0 - initial release
// =====================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant
);
  localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]         c_IDLE     = 2'd0;
  localparam logic [1:0]         c_BUSY     = 2'd1;
  localparam logic [1:0]         c_DONE     = 2'd2;
  localparam logic [1:0]         c_DRAIN    = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_last;
  logic               r_grant;
  logic               r_rw;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata0;
  logic [DATA_W-1:0]  r_rdata1;
  logic [c_CNT_W-1:0] r_cnt;

  logic w_any;
  logic w_pick;
  logic w_timeout;
  logic w_busy;
  logic w_mem_valid;
  logic w_p0_ready;
  logic w_p1_ready;

  assign w_any     = bus.p0_valid | bus.p1_valid;
  // On a tie the port that did not own the memory last wins
  assign w_pick    = (bus.p0_valid & bus.p1_valid) ? ~r_last : bus.p1_valid;
  assign w_timeout = (r_cnt == c_CNT_LAST) & ~bus.mem_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_any) w_next = c_BUSY;
      c_BUSY:  if (bus.mem_ready || w_timeout) w_next = c_DONE;
      c_DONE:  w_next = c_DRAIN;
      c_DRAIN: if (!bus.mem_ready) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != c_IDLE);
    w_mem_valid = (r_state == c_BUSY);
    w_p0_ready  = (r_state == c_DONE) & ~r_grant;
    w_p1_ready  = (r_state == c_DONE) &  r_grant;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_rw    <= w_pick ? bus.p1_rw    : bus.p0_rw;
            r_addr  <= w_pick ? bus.p1_addr  : bus.p0_addr;
            r_wdata <= w_pick ? bus.p1_wdata : bus.p0_wdata;
            r_cnt   <= '0;
          end
        end
        c_BUSY: begin
          // Exits at TIMEOUT-1 at the latest, so the extra MSB prevents wrap
          r_cnt <= r_cnt + 1'b1;
          if (bus.mem_ready) begin
            if (!r_rw) begin
              if (r_grant) r_rdata1 <= bus.mem_rdata;
              else         r_rdata0 <= bus.mem_rdata;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_grant) r_rdata1 <= '0;
            else         r_rdata0 <= '0;
          end
        end
        c_DRAIN: begin
          if (!bus.mem_ready) begin
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_valid = w_mem_valid;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.p0_ready  = w_p0_ready;
  assign bus.p1_ready  = w_p1_ready;
  assign bus.p0_err    = w_p0_ready & r_err;
  assign bus.p1_err    = w_p1_ready & r_err;
  assign bus.p0_rdata  = r_rdata0;
  assign bus.p1_rdata  = r_rdata1;
  assign busy          = w_busy;
  assign grant         = r_grant;

endmodule
`default_nettype wire
